// File: rtl/mnist_pkg.sv
// Shared types and encodings for the MNIST inference host sequencer.
// Status codes, FSM states and digit classification helper.
package mnist_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BADIDX  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int         NUM_CLASSES   = 10;
  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  // Any non-zero high bits on the prediction bus also mark the index as bad.
  function automatic logic [1:0] pred_status(input logic [3:0] digit, input logic upper_nz);
    return (upper_nz || (int'(digit) >= NUM_CLASSES)) ? ST_BADIDX : ST_OK;
  endfunction

endpackage

// File: rtl/mnist_infer_ctrl_if.sv
// Request, core and response signals of the inference sequencer.
// rsp_cycles (and CNT_W) exist only when MNIST_INFER_PERF_EN is defined.
interface mnist_infer_ctrl_if #(
  parameter int PRED_W = 16
`ifdef MNIST_INFER_PERF_EN
  , parameter int CNT_W = 32
`endif
);

  logic              req_valid;
  logic              req_ready;
  logic              core_start;
  logic              core_done;
  logic [PRED_W-1:0] core_pred;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [3:0]        rsp_digit;
  logic [1:0]        rsp_status;
  logic              busy;
  logic [15:0]       run_cnt;
`ifdef MNIST_INFER_PERF_EN
  logic [CNT_W-1:0]  rsp_cycles;
`endif

  modport master (
    input  req_valid, core_done, core_pred, rsp_ready,
`ifdef MNIST_INFER_PERF_EN
    output rsp_cycles,
`endif
    output req_ready, core_start, rsp_valid, rsp_digit, rsp_status, busy, run_cnt
  );

  modport slave (
    output req_valid, core_done, core_pred, rsp_ready,
`ifdef MNIST_INFER_PERF_EN
    input  rsp_cycles,
`endif
    input  req_ready, core_start, rsp_valid, rsp_digit, rsp_status, busy, run_cnt
  );

endinterface

// File: rtl/mnist_watchdog.sv
// Clearable up-counter with a terminal-count flag at TIMEOUT_CYCLES-1.
// Clear has priority over enable; count is registered, flag decodes the register.
module mnist_watchdog #(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mnist_infer_ctrl.sv
// Host sequencer for mnist_top: one start pulse per request, watchdog-bounded wait, registered
// result on a valid/ready channel (held until rsp_ready). MNIST_INFER_PERF_EN adds rsp_cycles.
module mnist_infer_ctrl
  import mnist_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int PRED_W         = 16,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mnist_infer_ctrl_if.master bus
);

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        core_start_q, core_start_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [3:0]  rsp_digit_q, rsp_digit_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [15:0] run_cnt_q, run_cnt_d;

  logic             wd_clr;
  logic             wd_en;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_tc;
  logic             done_seen;

  mnist_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .cnt   (wd_cnt),
    .tc    (wd_tc)
  );

  always_comb begin
    state_d      = state_q;
    rsp_digit_d  = rsp_digit_q;
    rsp_status_d = rsp_status_q;
    run_cnt_d    = run_cnt_q;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;
    // Watchdog is 0 only in the first WAIT cycle, where done may be a stale level.
    done_seen    = bus.core_done && (wd_cnt != '0);

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_START;
        end
      end
      S_START: begin
        wd_clr  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_en = 1'b1;
        if (done_seen) begin
          rsp_digit_d  = bus.core_pred[3:0];
          rsp_status_d = pred_status(bus.core_pred[3:0], |bus.core_pred[PRED_W-1:4]);
          state_d      = S_RESP;
        end else if (wd_tc) begin
          rsp_digit_d  = DIGIT_INVALID;
          rsp_status_d = ST_TIMEOUT;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          if (rsp_status_q == ST_OK) begin
            run_cnt_d = run_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are flops decoded from the next state so they line up with the state register.
    req_ready_d  = (state_d == S_IDLE);
    core_start_d = (state_d == S_START);
    busy_d       = (state_d == S_START) || (state_d == S_WAIT);
    rsp_valid_d  = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_digit_q  <= 4'h0;
      rsp_status_q <= ST_OK;
      run_cnt_q    <= 16'h0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_digit_q  <= rsp_digit_d;
      rsp_status_q <= rsp_status_d;
      run_cnt_q    <= run_cnt_d;
    end
  end

`ifdef MNIST_INFER_PERF_EN
  logic [CNT_W-1:0] rsp_cycles_q, rsp_cycles_d;

  // Loaded with the number of WAIT cycles spent, including the exit cycle.
  always_comb begin
    rsp_cycles_d = rsp_cycles_q;
    if ((state_q == S_WAIT) && (state_d == S_RESP)) begin
      rsp_cycles_d = wd_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_cycles_q <= '0;
    end else begin
      rsp_cycles_q <= rsp_cycles_d;
    end
  end

  assign bus.rsp_cycles = rsp_cycles_q;
`endif

  assign bus.req_ready  = req_ready_q;
  assign bus.core_start = core_start_q;
  assign bus.busy       = busy_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_digit  = rsp_digit_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.run_cnt    = run_cnt_q;

endmodule

// File: tb/tb_mnist_infer_ctrl.sv
// Directed and randomized bench for mnist_infer_ctrl with a behavioural core model.
// Checks rsp_cycles as well when MNIST_INFER_PERF_EN is defined.
module tb_mnist_infer_ctrl;

  localparam int TMO = 100;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   exp_run;

  mnist_infer_ctrl_if #(.PRED_W(16)) bus ();

  mnist_infer_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .PRED_W         (16),
    .CNT_W          (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction. done_at: WAIT cycle (1-based) at which the core raises done, 0 = never.
  // stale: done is left high from the previous run and never dropped.
  task automatic do_txn(input string name, input logic [15:0] pred, input int done_at,
                        input bit stale, input int hold);
    int         end_w;
    bit         timed_out;
    logic [3:0] e_digit;
    logic [1:0] e_status;

    // Reference: the response is taken at the first WAIT cycle >= 2 with done high, else at TMO.
    if (stale) begin
      end_w = 2;
      timed_out = 1'b0;
    end else if (done_at > 0 && done_at <= TMO) begin
      end_w = (done_at < 2) ? 2 : done_at;
      timed_out = 1'b0;
    end else begin
      end_w = TMO;
      timed_out = 1'b1;
    end
    if (timed_out) begin
      e_digit  = 4'hF;
      e_status = 2'b10;
    end else begin
      e_digit  = pred[3:0];
      e_status = (pred[15:4] != 12'h0 || pred[3:0] > 4'd9) ? 2'b01 : 2'b00;
    end

    bus.core_pred = pred;
    bus.req_valid = 1'b1;
    chk({name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    if (!stale) bus.core_done = 1'b0;
    chk({name, "_start"}, 32'({bus.core_start, bus.busy, bus.req_ready, bus.rsp_valid}),
        32'(4'b1100));

    for (int w = 1; w <= end_w; w++) begin
      step();
      if (!stale && done_at > 0 && w >= done_at) bus.core_done = 1'b1;
      chk($sformatf("%s_wait%0d", name, w),
          32'({bus.busy, bus.rsp_valid, bus.core_start, bus.req_ready}), 32'(4'b1000));
    end

    step();
    bus.rsp_ready = (hold == 0);
    chk({name, "_rsp_flags"}, 32'({bus.rsp_valid, bus.busy, bus.req_ready, bus.core_start}),
        32'(4'b1000));
    chk({name, "_digit"}, 32'(bus.rsp_digit), 32'(e_digit));
    chk({name, "_status"}, 32'(bus.rsp_status), 32'(e_status));
    chk({name, "_run_cnt_rsp"}, 32'(bus.run_cnt), 32'(exp_run[15:0]));
`ifdef MNIST_INFER_PERF_EN
    chk({name, "_rsp_cycles"}, bus.rsp_cycles, 32'(end_w));
`endif

    if (hold > 0) begin
      bus.req_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        step();
        chk($sformatf("%s_hold%0d", name, h),
            32'({bus.rsp_valid, bus.req_ready, bus.core_start, bus.busy,
                 bus.rsp_status, bus.rsp_digit}),
            32'({4'b1000, e_status, e_digit}));
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
    end

    step();
    if (e_status == 2'b00) exp_run = (exp_run + 1) & 16'hFFFF;
    chk({name, "_idle"}, 32'({bus.rsp_valid, bus.req_ready, bus.core_start, bus.busy}),
        32'(4'b0100));
    chk({name, "_run_cnt"}, 32'(bus.run_cnt), 32'(exp_run[15:0]));
    step();
    chk({name, "_no_extra_start"}, 32'({bus.core_start, bus.req_ready}), 32'(2'b01));
  endtask

  initial begin
    logic [15:0] rp;
    logic [3:0]  rd;
    int          sel;

    vectors       = 0;
    miscompares   = 0;
    exp_run       = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.core_done = 1'b0;
    bus.core_pred = 16'h0;
    bus.rsp_ready = 1'b1;

    step();
    step();
    chk("reset_flags", 32'({bus.req_ready, bus.core_start, bus.busy, bus.rsp_valid}),
        32'(4'b1000));
    chk("reset_rsp", 32'({bus.rsp_status, bus.rsp_digit}), 32'd0);
    chk("reset_run_cnt", 32'(bus.run_cnt), 32'd0);
`ifdef MNIST_INFER_PERF_EN
    chk("reset_rsp_cycles", bus.rsp_cycles, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    do_txn("normal", 16'h0007, 51, 1'b0, 0);
    do_txn("timeout", 16'h0002, 0, 1'b0, 0);
    do_txn("bad_c", 16'h000C, 10, 1'b0, 0);
    do_txn("bad_hi", 16'h0103, 5, 1'b0, 0);
    do_txn("stale", 16'h0005, 0, 1'b1, 0);
    do_txn("backpr", 16'h0003, 8, 1'b0, 20);
    do_txn("done_tmo", 16'h0009, TMO, 1'b0, 0);

    // Asynchronous reset in WAIT cycle 30.
    bus.core_pred = 16'h0004;
    bus.core_done = 1'b0;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 30; i++) step();
    rst_n = 1'b0;
    #1;
    exp_run = 0;
    chk("arst_flags", 32'({bus.req_ready, bus.core_start, bus.busy, bus.rsp_valid}),
        32'(4'b1000));
    chk("arst_rsp", 32'({bus.rsp_status, bus.rsp_digit}), 32'd0);
    chk("arst_run_cnt", 32'(bus.run_cnt), 32'd0);
`ifdef MNIST_INFER_PERF_EN
    chk("arst_rsp_cycles", bus.rsp_cycles, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    do_txn("post_rst", 16'h0001, 20, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      sel = int'($urandom_range(0, 3));
      rd  = 4'($urandom_range(0, 9));
      if (sel <= 1)      rp = {12'h0, rd};
      else if (sel == 2) rp = {12'h0, 4'($urandom_range(10, 15))};
      else               rp = {12'($urandom_range(1, 4095)), rd};
      do_txn($sformatf("rnd%0d", n), rp, int'($urandom_range(0, 130)), 1'b0,
             int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
